// File: rtl/square_acc.sv
// Iterative square-and-add: y = a*a + r via a 1-bit-per-cycle shift-add multiplier.
// Define SQUARE_ACC_EARLY_EXIT_EN to leave MUL as soon as no multiplier bits remain.
module square_acc #(
  parameter int WIDTH   = 8,
  parameter int R_WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_bi,
  input  logic [R_WIDTH-1:0] r_bi,
  output logic [2*WIDTH:0]   y_bo,
  output logic               busy_o,
  output logic               done_o
);

  localparam int AW = 2*WIDTH+1;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_ADD  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [2*WIDTH-1:0] mc;
  logic [WIDTH-1:0]   m;
  logic [AW-1:0]      acc;
  logic [R_WIDTH-1:0] r_q;
  logic [CW-1:0]      cnt;

  logic mul_last;
  logic load;
  logic step;
  logic add_r;
  logic fin;
  logic clr;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    mul_last = (cnt == CW'(WIDTH-1));
`ifdef SQUARE_ACC_EARLY_EXIT_EN
    mul_last = mul_last | ((m >> 1) == '0);
`endif
    case (state)
      S_IDLE:  if (start_i) state_nx = S_MUL;
      S_MUL:   if (mul_last) state_nx = S_ADD;
      S_ADD:   state_nx = S_FIN;
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    load  = 1'b0;
    step  = 1'b0;
    add_r = 1'b0;
    fin   = 1'b0;
    clr   = 1'b0;
    case (state)
      S_IDLE:  load  = start_i;
      S_MUL:   step  = 1'b1;
      S_ADD:   add_r = 1'b1;
      S_FIN:   fin   = 1'b1;
      default: clr   = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mc     <= '0;
      m      <= '0;
      acc    <= '0;
      r_q    <= '0;
      cnt    <= '0;
      y_bo   <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      done_o <= fin;
      if (load) begin
        mc     <= {{WIDTH{1'b0}}, a_bi};
        m      <= a_bi;
        r_q    <= r_bi;
        acc    <= '0;
        cnt    <= '0;
        busy_o <= 1'b1;
      end
      if (step) begin
        if (m[0]) acc <= acc + {1'b0, mc};
        mc  <= mc << 1;
        m   <= m >> 1;
        cnt <= cnt + CW'(1);
      end
      if (add_r) acc <= acc + AW'(r_q);
      // result is published only here, so an aborted op never leaks
      if (fin) begin
        y_bo   <= acc;
        busy_o <= 1'b0;
      end
      if (clr) busy_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_square_acc.sv
// Bench for square_acc: transaction-level reference model plus directed
// and randomized stimulus; honours SQUARE_ACC_EARLY_EXIT_EN.
module tb_square_acc;

  localparam int W  = 8;
  localparam int RW = 8;

`ifdef SQUARE_ACC_EARLY_EXIT_EN
  localparam int L_A5   = 5;
  localparam int L_A0   = 3;
  localparam int L_A1   = 3;
`else
  localparam int L_A5   = 10;
  localparam int L_A0   = 10;
  localparam int L_A1   = 10;
`endif
  localparam int L_A128 = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  a;
  logic [RW-1:0] r;
  logic [2*W:0]  y;
  logic          busy;
  logic          done;

  int errs   = 0;
  int checks = 0;
  bit chk_on = 0;

  square_acc #(.WIDTH(W), .R_WIDTH(RW)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .start_i(start),
    .a_bi   (a),
    .r_bi   (r),
    .y_bo   (y),
    .busy_o (busy),
    .done_o (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int lat(input int av);
`ifdef SQUARE_ACC_EARLY_EXIT_EN
    int msb;
    msb = 0;
    for (int i = 0; i < W; i++) if (av[i]) msb = i;
    return msb + 3;
`else
    return W + 2;
`endif
  endfunction

  // Model: an accepted request keeps busy for lat(a) cycles, then publishes.
  int m_left = 0;
  int m_y    = 0;
  int m_pend = 0;
  bit m_done = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0;
      m_y    = 0;
      m_done = 0;
    end else begin
      m_done = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_y    = m_pend;
          m_done = 1;
        end
      end else if (start) begin
        m_pend = int'(a) * int'(a) + int'(r);
        m_left = lat(int'(a));
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy", {31'd0, busy}, {31'd0, m_left > 0});
      chk("done", {31'd0, done}, {31'd0, m_done});
      chk("y", 32'(y), m_y);
    end
  end

  task automatic run_op(input int av, input int rv, output int nb);
    bit got;
    got = 0;
    nb  = 0;
    @(negedge clk);
    start = 1'b1;
    a = W'(av);
    r = RW'(rv);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        got = 1;
        break;
      end
      if (busy) nb++;
      @(negedge clk);
    end
    chk("op_timeout", {31'd0, got}, 32'd1);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    chk("drain_idle", {31'd0, busy}, 32'd0);
    @(negedge clk);
  endtask

  int nb;
  int nd;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    r     = '0;
    repeat (2) @(negedge clk);
    chk_on = 1;
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;

    run_op(5, 3, nb);
    chk("basic_y", 32'(y), 32'd28);
    chk("basic_lat", nb, L_A5);

    run_op(255, 255, nb);
    chk("max_y", 32'(y), 32'd65280);
    run_op(0, 6, nb);
    chk("zero_y", 32'(y), 32'd6);
    chk("zero_lat", nb, L_A0);

    // requests and operand changes while busy must be ignored
    @(negedge clk);
    start = 1'b1; a = 8'd3; r = 8'd1;
    @(negedge clk);
    a = 8'd7; r = 8'd9;
    @(negedge clk);
    a = 8'd100; r = 8'd50;
    @(negedge clk);
    start = 1'b0;
    drain();
    chk("blk_y", 32'(y), 32'd10);
    nd = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy) nd++;
    end
    chk("blk_no_second", nd, 0);

    // reset on the 4th busy cycle
    @(negedge clk);
    start = 1'b1; a = 8'd200; r = 8'd2;
    @(negedge clk);
    start = 1'b0;
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy) nd++;
      if (nd == 4) break;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_y", 32'(y), 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    run_op(2, 2, nb);
    chk("post_rst_y", 32'(y), 32'd6);

    // back-to-back with start held high
    @(negedge clk);
    start = 1'b1; a = 8'd4; r = 8'd1;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) begin
        nd++;
        chk("b2b_y", 32'(y), 32'd17);
      end
    end
    start = 1'b0;
    chk("b2b_count", {31'd0, nd >= 3}, 32'd1);
    drain();

    run_op(1, 9, nb);
    chk("a1_y", 32'(y), 32'd10);
    chk("a1_lat", nb, L_A1);
    run_op(128, 7, nb);
    chk("a128_y", 32'(y), 32'd16391);
    chk("a128_lat", nb, L_A128);

    // random traffic, including start and operand noise while busy
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 5))
        0:       a = '0;
        1:       a = '1;
        default: a = W'($urandom);
      endcase
      r = RW'($urandom);
      rst = ($urandom_range(0, 499) == 0);
    end
    start = 1'b0;
    rst   = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
